// File: rtl/rep_mult_pkg.sv
// Shared definitions for the repeated-addition multiplier.
//   state_t       : FSM state encoding (ST_IDLE=0, ST_RUN=1, ST_DONE=2)
//   DEFAULT_WIDTH : default operand width for rep_add_mult
package rep_mult_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rep_add_mult_add_w.sv
// add_w: parametrised combinational adder, the accumulate datapath.
// Ports:
//   in1, in2 : W-bit addends
//   out1     : W-bit sum (carry out discarded; callers size W so it cannot overflow)
module add_w #(
  parameter int W = 32
) (
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic [W-1:0] out1
);

  assign out1 = in1 + in2;

endmodule

// File: rtl/rep_add_mult.sv
// rep_add_mult: sequential unsigned multiplier that adds the multiplicand
// into an accumulator once per clock, repeat-count times.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   start   : request a multiply (accepted only in IDLE)
//   a, b    : WIDTH-bit unsigned multiplicand / multiplier (repeat count)
//   busy    : high in RUN and DONE
//   done    : one-cycle pulse, product valid
//   product : 2*WIDTH-bit result, held until next completion or reset
// Optional build macro REP_ADD_MULT_MIN_SWAP_EN: on accept, loop min(a,b)
// times over max(a,b) (ties keep a as multiplicand) to shorten latency.
module rep_add_mult
  import rep_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int P_WIDTH = 2 * WIDTH;

  state_t             state;
  logic [P_WIDTH-1:0] acc;
  logic [P_WIDTH-1:0] mcand;
  logic [P_WIDTH-1:0] sum;
  logic [WIDTH-1:0]   count;

  // Operand selection at accept time
  logic [WIDTH-1:0]   mcand_sel;
  logic [WIDTH-1:0]   count_sel;

`ifdef REP_ADD_MULT_MIN_SWAP_EN
  // Smaller operand becomes the repeat count; on a tie a stays multiplicand.
  always_comb begin
    mcand_sel = a;
    count_sel = b;
    if (a < b) begin
      mcand_sel = b;
      count_sel = a;
    end
  end
`else
  always_comb begin
    mcand_sel = a;
    count_sel = b;
  end
`endif

  add_w #(
    .W(P_WIDTH)
  ) u_add (
    .in1 (acc),
    .in2 (mcand),
    .out1(sum)
  );

  // busy/done are registered alongside the state so they equal
  // (state != IDLE) and (state == DONE) without output decode logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      count   <= '0;
      mcand   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            mcand <= P_WIDTH'(mcand_sel);
            count <= count_sel;
            acc   <= '0;
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (count != '0) begin
            acc   <= sum;
            count <= count - WIDTH'(1);
          end else begin
            product <= acc;
            state   <= ST_DONE;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rep_add_mult.sv
module tb_rep_add_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_cmp  = 0;
  int n_fail = 0;

  // busy seen at the negedge following edge N+i of the last operation
  logic busy_h [0:4095];

  rep_add_mult #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  // Reference model: product is the plain arithmetic product; edges from
  // accept to the edge that raises done equal repeat count + 1.
  function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  function automatic int ref_lat(input logic [15:0] x, input logic [15:0] y);
`ifdef REP_ADD_MULT_MIN_SWAP_EN
    return ((x < y) ? int'(x) : int'(y)) + 1;
`else
    return int'(y) + 1;
`endif
  endfunction

  // Drives one operation accepted at edge N. Observes at the negedge after
  // edges N+0..N+budget. lat = first i with done high (-1 if none).
  // spam keeps start high throughout with operands 2x1.
  task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input bit spam,
                       input int budget, output int lat, output logic [31:0] prod,
                       output int ndone);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    lat = -1; prod = '0; ndone = 0;
    for (int i = 0; i <= budget; i++) begin
      @(negedge clk);
      busy_h[i] = busy;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat  = i;
          prod = product;
        end
      end
      if (spam) begin
        a = 16'd2; b = 16'd1;
      end else begin
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 16'd5; b = 16'd5;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b product=%0d, required 0/0/0", busy, done, product);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_basic;
    int lat, nd; logic [31:0] p;
    do_op(16'd7, 16'd5, 1'b0, ref_lat(7, 5) + 4, lat, p, nd);
    n_cmp++;
    if (busy_h[0] !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy: busy=%b, required 1", busy_h[0]);
    end
    n_cmp++;
    if (lat !== ref_lat(7, 5)) begin
      n_fail++; $display("FAIL basic_lat: lat=%0d, required %0d", lat, ref_lat(7, 5));
    end
    n_cmp++;
    if (p !== 32'd35) begin
      n_fail++; $display("FAIL basic_prod: product=%0d, required 35", p);
    end
    n_cmp++;
    if (lat >= 0 && busy_h[lat + 1] !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_after: busy=%b, required 0", busy_h[lat + 1]);
    end
    n_cmp++;
    if (product !== 32'd35) begin
      n_fail++; $display("FAIL basic_hold: product=%0d, required 35", product);
    end
  endtask

  task automatic test_boundaries;
    logic [15:0] va [4] = '{16'hFFFF, 16'd9, 16'd0, 16'd1};
    logic [15:0] vb [4] = '{16'd3,    16'd0, 16'd4, 16'd1};
    int lat, nd; logic [31:0] p;
    for (int k = 0; k < 4; k++) begin
      do_op(va[k], vb[k], 1'b0, ref_lat(va[k], vb[k]) + 4, lat, p, nd);
      n_cmp++;
      if (lat !== ref_lat(va[k], vb[k]) || p !== ref_prod(va[k], vb[k]) || nd !== 1) begin
        n_fail++;
        $display("FAIL boundary a=%0d b=%0d: lat=%0d product=%0d dones=%0d, required %0d/%0d/1",
                 va[k], vb[k], lat, p, nd, ref_lat(va[k], vb[k]), ref_prod(va[k], vb[k]));
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, nd; logic [31:0] p;
    do_op(16'd6, 16'd4, 1'b1, ref_lat(6, 4) + 2, lat, p, nd);
    n_cmp++;
    if (lat !== ref_lat(6, 4) || p !== 32'd24 || nd !== 1) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d product=%0d dones=%0d, required %0d/24/1",
               lat, p, nd, ref_lat(6, 4));
    end
    // start held high: DONE->IDLE edge ignores it, the following edge accepts
    n_cmp++;
    if (lat >= 0 && (busy_h[lat + 1] !== 1'b0 || busy_h[lat + 2] !== 1'b1)) begin
      n_fail++;
      $display("FAIL b2b_reaccept: busy after done=%b,%b, required 0,1",
               busy_h[lat + 1], busy_h[lat + 2]);
    end
    n_cmp++;
    if (product !== 32'd2) begin
      n_fail++; $display("FAIL b2b_second: product=%0d, required 2", product);
    end
  endtask

  task automatic test_reset_mid;
    int nd, lat; logic [31:0] p;
    @(negedge clk);
    a = 16'd100; b = 16'd50; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b done=%b product=%0d, required 0/0/0", busy, done, product);
    end
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    n_cmp++;
    if (nd !== 0) begin
      n_fail++; $display("FAIL mid_reset_nodone: dones=%0d, required 0", nd);
    end
    do_op(16'd3, 16'd3, 1'b0, ref_lat(3, 3) + 4, lat, p, nd);
    n_cmp++;
    if (p !== 32'd9 || lat !== ref_lat(3, 3)) begin
      n_fail++; $display("FAIL mid_reset_after: product=%0d lat=%0d, required 9/%0d", p, lat, ref_lat(3, 3));
    end
  endtask

  task automatic test_swap;
    logic [15:0] va [2] = '{16'd1000, 16'd3};
    logic [15:0] vb [2] = '{16'd3,    16'd1000};
    int lat, nd; logic [31:0] p;
    for (int k = 0; k < 2; k++) begin
      do_op(va[k], vb[k], 1'b0, ref_lat(va[k], vb[k]) + 4, lat, p, nd);
      n_cmp++;
      if (lat !== ref_lat(va[k], vb[k]) || p !== 32'd3000) begin
        n_fail++;
        $display("FAIL swap a=%0d b=%0d: lat=%0d product=%0d, required %0d/3000",
                 va[k], vb[k], lat, p, ref_lat(va[k], vb[k]));
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] ra, rb;
    int lat, nd; logic [31:0] p;
    for (int k = 0; k < 20; k++) begin
      ra = (k % 3 == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      rb = (k % 3 == 1) ? 16'($urandom) : 16'($urandom_range(0, 40));
      if (ref_lat(ra, rb) > 2000) rb = 16'($urandom_range(0, 40));
      do_op(ra, rb, 1'b0, ref_lat(ra, rb) + 4, lat, p, nd);
      n_cmp++;
      if (lat !== ref_lat(ra, rb) || p !== ref_prod(ra, rb) || nd !== 1) begin
        n_fail++;
        $display("FAIL random a=%0d b=%0d: lat=%0d product=%0d dones=%0d, required %0d/%0d/1",
                 ra, rb, lat, p, nd, ref_lat(ra, rb), ref_prod(ra, rb));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    test_swap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
